wb_mem_port_arbiter: RTL and testbench

- Shares one Wishbone classic slave memory between the core's instruction port (M0) and data port (M1).
- Used in builds where only a single controller memory is exposed, i.e. ENABLE_SECOND_MEMORY is off.
- Round-robin grant with one arbitration cycle and single-beat release after every ack.
- A bus-timeout watchdog returns err to the granted master if the slave never acks.

---
 rtl/wb_mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_mem_port_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_port_arbiter.sv
// Two-master Wishbone classic arbiter in front of a single slave memory:
// round-robin grant, release after every ack, optional no-ack watchdog.
module wb_mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i,
    output logic [1:0]              grant_o,
    output logic                    timeout_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_rr_last;
    logic             w_rr_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_req0;
    logic w_req1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_gnt_any;
    logic w_gnt_stb;
    logic w_own_req;
    logic w_other_req;
    logic w_to_hit;
    logic w_abort;
    logic w_release;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    assign w_gnt0    = (r_state == ST_GNT0);
    assign w_gnt1    = (r_state == ST_GNT1);
    assign w_gnt_any = w_gnt0 | w_gnt1;
    assign w_gnt_stb = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
    assign w_own_req   = w_gnt0 ? w_req0 : w_req1;
    assign w_other_req = w_gnt0 ? w_req1 : w_req0;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);
            assign w_to_hit = w_gnt_any & (r_cnt == TO_VAL);
        end else begin : g_no_wdog
            assign w_to_hit = 1'b0;
        end
    endgenerate

    // An ack landing on the timeout cycle wins: the beat completes, no err.
    assign w_abort   = w_to_hit & ~s_ack_i;
    assign w_release = w_gnt_any & (s_ack_i | w_to_hit);

    always_comb begin
        w_state_nxt   = r_state;
        w_rr_last_nxt = r_rr_last;
        w_cnt_nxt     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_state_nxt = r_rr_last ? ST_GNT0 : ST_GNT1;
                end else if (w_req0) begin
                    w_state_nxt = ST_GNT0;
                end else if (w_req1) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (w_release) begin
                    w_rr_last_nxt = w_gnt1;
                    if (w_other_req) begin
                        w_state_nxt = w_gnt0 ? ST_GNT1 : ST_GNT0;
                    end else if (!w_own_req) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!w_gnt_stb) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_last <= w_rr_last_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    // Handshake: stb is the valid of a beat, ack/err its completion; the granted
    // master holds its controls stable until one of them is returned.
    assign s_cyc_o  = ((w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i)) & ~w_to_hit;
    assign s_stb_o  = w_gnt_stb & ~w_to_hit;
    assign s_we_o   = (w_gnt0 & m0_we_i) | (w_gnt1 & m1_we_i);
    assign s_sel_o  = ({SEL_W{w_gnt0}} & m0_sel_i) | ({SEL_W{w_gnt1}} & m1_sel_i);
    assign s_addr_o = ({ADDR_WIDTH{w_gnt0}} & m0_addr_i) | ({ADDR_WIDTH{w_gnt1}} & m1_addr_i);
    assign s_data_o = ({DATA_WIDTH{w_gnt0}} & m0_data_i) | ({DATA_WIDTH{w_gnt1}} & m1_data_i);

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = s_ack_i & w_gnt0;
    assign m1_ack_o  = s_ack_i & w_gnt1;
    assign m0_err_o  = w_abort & w_gnt0;
    assign m1_err_o  = w_abort & w_gnt1;
    assign timeout_o = w_abort;
    assign grant_o   = {w_gnt1, w_gnt0};

endmodule

// File: tb/tb_wb_mem_port_arbiter.sv
// Bench for wb_mem_port_arbiter: directed scenarios plus a randomized two-master
// run scored against a transaction-level arbitration and memory model.
`timescale 1ns/1ps
module tb_wb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          sys_clk;
    logic          rst_n;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_data_i, m0_data_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i, m1_data_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o, s_data_i;
    logic          s_ack_i;
    logic [1:0]    grant_o;
    logic          timeout_o;

    int n_checks = 0;
    int n_fails  = 0;

    logic [DW-1:0] slave_mem [logic [AW-1:0]];
    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];
    logic          busy   [2];
    logic          t_we   [2];
    logic [AW-1:0] t_addr [2];
    logic [DW-1:0] t_data [2];
    logic [SW-1:0] t_sel  [2];

    wb_mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    // Clock and hard time limit
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Driver tasks
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_addr_i = '0; m0_data_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_addr_i = '0; m1_data_i = '0;
        s_ack_i = 0; s_data_i = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge sys_clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_m0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = we; m0_sel_i = '1; m0_addr_i = a; m0_data_i = d;
    endtask

    task automatic drive_m1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = we; m1_sel_i = '1; m1_addr_i = a; m1_data_i = d;
    endtask

    // Memory model helpers
    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic issue_txn(input int m);
        logic [AW-1:0] a;
        logic [DW-1:0] cur;
        a = ((m == 0) ? 32'h0000_0000 : 32'h0000_1000) + AW'($urandom_range(0, 15) * 4);
        t_addr[m] = a;
        t_we[m]   = 1'($urandom_range(0, 1));
        t_data[m] = $urandom;
        t_sel[m]  = SW'($urandom_range(1, 15));
        cur = model_mem.exists(a) ? model_mem[a] : init_word(a);
        if (t_we[m]) model_mem[a] = merge(cur, t_data[m], t_sel[m]);
        else if (m == 0) exp_q0.push_back(cur);
        else exp_q1.push_back(cur);
        busy[m] = 1'b1;
    endtask

    task automatic drive_masters();
        m0_stb_i  = busy[0];
        m0_cyc_i  = busy[0] | 1'($urandom_range(0, 1));
        m0_we_i   = busy[0] ? t_we[0]   : 1'($urandom_range(0, 1));
        m0_addr_i = busy[0] ? t_addr[0] : $urandom;
        m0_data_i = busy[0] ? t_data[0] : $urandom;
        m0_sel_i  = busy[0] ? t_sel[0]  : SW'($urandom_range(0, 15));
        m1_stb_i  = busy[1];
        m1_cyc_i  = busy[1] | 1'($urandom_range(0, 1));
        m1_we_i   = busy[1] ? t_we[1]   : 1'($urandom_range(0, 1));
        m1_addr_i = busy[1] ? t_addr[1] : $urandom;
        m1_data_i = busy[1] ? t_data[1] : $urandom;
        m1_sel_i  = busy[1] ? t_sel[1]  : SW'($urandom_range(0, 15));
    endtask

    // Scenario tasks
    task automatic test_reset();
        rst_n = 1'b1;
        drive_idle();
        #2 rst_n = 1'b0;
        drive_m0(1'b1, 32'h1234, 32'hAAAA_5555);
        drive_m1(1'b1, 32'h5678, 32'h5555_AAAA);
        s_ack_i = 1'b1;
        repeat (3) @(posedge sys_clk);
        #2;
        n_checks++;
        if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000 || s_sel_o !== '0 || s_addr_o !== '0 || s_data_o !== '0) begin
            n_fails++;
            $display("FAIL reset_slave_side: cyc/stb/we=%b sel=%h addr=%h data=%h expected all 0",
                     {s_cyc_o, s_stb_o, s_we_o}, s_sel_o, s_addr_o, s_data_o);
        end
        n_checks++;
        if (grant_o !== 2'b00) begin
            n_fails++; $display("FAIL reset_grant: grant_o=%b expected 00", grant_o);
        end
        n_checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o} !== 5'b0) begin
            n_fails++;
            $display("FAIL reset_master_side: ack0/ack1/err0/err1/timeout=%b expected 00000",
                     {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o});
        end
        drive_idle();
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        drive_m0(1'b0, 32'h100, 32'h0);
        m0_sel_i = 4'b1111;
        #1;
        n_checks++;
        if (s_stb_o !== 1'b0) begin
            n_fails++; $display("FAIL single_arb_cycle: s_stb_o=%b expected 0", s_stb_o);
        end
        step();
        n_checks++;
        if (s_stb_o !== 1'b1 || s_addr_o !== 32'h100 || grant_o !== 2'b01) begin
            n_fails++;
            $display("FAIL single_stb_rise: stb=%b addr=%h grant=%b expected 1 00000100 01",
                     s_stb_o, s_addr_o, grant_o);
        end
        step();
        n_checks++;
        if (m0_ack_o !== 1'b0) begin
            n_fails++; $display("FAIL single_no_early_ack: m0_ack_o=%b expected 0", m0_ack_o);
        end
        step();
        s_ack_i = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (m0_ack_o !== 1'b1 || m0_data_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0) begin
            n_fails++;
            $display("FAIL single_ack: m0_ack=%b m0_data=%h m1_ack=%b expected 1 deadbeef 0",
                     m0_ack_o, m0_data_o, m1_ack_o);
        end
        step();
        drive_idle();
        #1;
        n_checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            n_fails++; $display("FAIL single_ack_pulse: m0_ack=%b m1_ack=%b expected 0 0", m0_ack_o, m1_ack_o);
        end
        step();
        n_checks++;
        if (grant_o !== 2'b00) begin
            n_fails++; $display("FAIL single_back_idle: grant_o=%b expected 00", grant_o);
        end
    endtask

    task automatic test_tie_first();
        do_reset();
        drive_m0(1'b0, 32'h0, 32'h0);
        drive_m1(1'b1, 32'h2000, 32'h1234_5678);
        step();
        s_ack_i = 1'b1;
        s_data_i = 32'h0BAD_F00D;
        #1;
        n_checks++;
        if (grant_o !== 2'b01 || s_we_o !== 1'b0 || s_addr_o !== 32'h0 || m0_ack_o !== 1'b1) begin
            n_fails++;
            $display("FAIL tie_m0_first: grant=%b we=%b addr=%h ack0=%b expected 01 0 00000000 1",
                     grant_o, s_we_o, s_addr_o, m0_ack_o);
        end
        step();
        m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        n_checks++;
        if (grant_o !== 2'b10 || s_stb_o !== 1'b1 || s_we_o !== 1'b1 || s_addr_o !== 32'h2000 ||
            s_data_o !== 32'h1234_5678 || s_sel_o !== 4'b1111) begin
            n_fails++;
            $display("FAIL tie_m1_no_bubble: grant=%b stb=%b we=%b addr=%h data=%h sel=%b expected 10 1 1 00002000 12345678 1111",
                     grant_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o);
        end
        n_checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            n_fails++; $display("FAIL tie_m1_ack: m1_ack=%b m0_ack=%b expected 1 0", m1_ack_o, m0_ack_o);
        end
        step();
        drive_idle();
        step();
    endtask

    task automatic test_back_to_back();
        int acks0;
        int acks1;
        int last;
        int who;
        logic [1:0] exp_g;
        do_reset();
        drive_m0(1'b0, 32'h40, 32'h0);
        drive_m1(1'b1, 32'h1040, 32'hCAFE_0001);
        s_ack_i = 1'b1;
        s_data_i = 32'hA0A0_0000;
        acks0 = 0; acks1 = 0; last = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            who = 1 - last;
            exp_g = (who == 0) ? 2'b01 : 2'b10;
            last = who;
            n_checks++;
            if (grant_o !== exp_g) begin
                n_fails++; $display("FAIL b2b_grant[%0d]: grant_o=%b expected %b", i, grant_o, exp_g);
            end
            acks0 += int'(m0_ack_o);
            acks1 += int'(m1_ack_o);
        end
        n_checks++;
        if (acks0 != 4 || acks1 != 4) begin
            n_fails++; $display("FAIL b2b_ack_count: m0=%0d m1=%0d expected 4 4", acks0, acks1);
        end
        step();
        drive_idle();
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        drive_m1(1'b1, 32'h1000, 32'h0000_0005);
        step();
        drive_m0(1'b0, 32'h8, 32'h0);
        for (int w = 1; w <= TO; w++) begin
            #1;
            n_checks++;
            if (grant_o !== 2'b10 || s_stb_o !== 1'b1 || m1_err_o !== 1'b0 || timeout_o !== 1'b0) begin
                n_fails++;
                $display("FAIL timeout_wait[%0d]: grant=%b stb=%b err1=%b to=%b expected 10 1 0 0",
                         w, grant_o, s_stb_o, m1_err_o, timeout_o);
            end
            step();
        end
        #1;
        n_checks++;
        if (m1_err_o !== 1'b1 || timeout_o !== 1'b1 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 ||
            m0_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_abort: err1=%b to=%b stb=%b cyc=%b err0=%b ack1=%b expected 1 1 0 0 0 0",
                     m1_err_o, timeout_o, s_stb_o, s_cyc_o, m0_err_o, m1_ack_o);
        end
        step();
        m1_cyc_i = 0; m1_stb_i = 0;
        #1;
        n_checks++;
        if (grant_o !== 2'b01 || s_addr_o !== 32'h8 || timeout_o !== 1'b0) begin
            n_fails++;
            $display("FAIL timeout_regrant: grant=%b addr=%h to=%b expected 01 00000008 0",
                     grant_o, s_addr_o, timeout_o);
        end
        s_ack_i = 1'b1;
        step();
        drive_idle();
        step();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        drive_m1(1'b0, 32'h1004, 32'h0);
        repeat (TO + 1) step();
        s_ack_i = 1'b1;
        s_data_i = 32'h7777_1111;
        #1;
        n_checks++;
        if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0 || timeout_o !== 1'b0 || m1_data_o !== 32'h7777_1111) begin
            n_fails++;
            $display("FAIL ack_wins: ack1=%b err1=%b to=%b data=%h expected 1 0 0 77771111",
                     m1_ack_o, m1_err_o, timeout_o, m1_data_o);
        end
        step();
        drive_idle();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_m1(1'b0, 32'h1008, 32'h0);
        step();
        step();
        s_ack_i = 1'b1;
        #1;
        n_checks++;
        if (m1_ack_o !== 1'b1 || s_cyc_o !== 1'b1) begin
            n_fails++; $display("FAIL areset_pre: ack1=%b cyc=%b expected 1 1", m1_ack_o, s_cyc_o);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m1_ack_o !== 1'b0) begin
            n_fails++;
            $display("FAIL areset_drop: cyc=%b grant=%b ack1=%b expected 0 00 0", s_cyc_o, grant_o, m1_ack_o);
        end
        s_ack_i = 1'b0;
        drive_m0(1'b0, 32'h10, 32'h0);
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (grant_o !== 2'b01) begin
            n_fails++; $display("FAIL areset_tie_m0: grant_o=%b expected 01", grant_o);
        end
        step();
        drive_idle();
        step();
    endtask

    task automatic test_random();
        int owner;
        int served;
        int last;
        int lat;
        int wcnt;
        bit armed;
        bit ack;
        bit req0;
        bit req1;
        logic [1:0] exp_g;
        logic exp_stb;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] sa;
        do_reset();
        owner = -1; last = 1; armed = 0; lat = 0; wcnt = 0;
        busy[0] = 0; busy[1] = 0;
        exp_q0.delete(); exp_q1.delete(); slave_mem.delete(); model_mem.delete();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc >= 400 && !busy[0] && !busy[1]) break;
            for (int m = 0; m < 2; m++)
                if (cyc < 400 && !busy[m] && $urandom_range(0, 99) < 45) issue_txn(m);
            drive_masters();
            #1;
            ack = 0;
            if (s_stb_o) begin
                if (!armed) begin armed = 1; lat = $urandom_range(0, 3); wcnt = 0; end
                if (wcnt == lat) ack = 1;
                else wcnt++;
            end
            sa = s_addr_o;
            s_ack_i = ack;
            if (ack && !s_we_o) s_data_i = slave_mem.exists(sa) ? slave_mem[sa] : init_word(sa);
            else s_data_i = $urandom;
            if (ack && s_we_o)
                slave_mem[sa] = merge(slave_mem.exists(sa) ? slave_mem[sa] : init_word(sa), s_data_o, s_sel_o);
            if (ack) armed = 0;
            #1;
            exp_g = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            exp_stb = (owner >= 0) && busy[owner];
            n_checks++;
            if (grant_o !== exp_g) begin
                n_fails++; $display("FAIL rnd_grant@%0d: grant_o=%b expected %b", cyc, grant_o, exp_g);
            end
            n_checks++;
            if (s_stb_o !== exp_stb) begin
                n_fails++; $display("FAIL rnd_stb@%0d: s_stb_o=%b expected %b", cyc, s_stb_o, exp_stb);
            end
            if (exp_stb) begin
                n_checks++;
                if (s_addr_o !== t_addr[owner] || s_we_o !== t_we[owner] || s_sel_o !== t_sel[owner] ||
                    (t_we[owner] && s_data_o !== t_data[owner])) begin
                    n_fails++;
                    $display("FAIL rnd_route@%0d: addr=%h we=%b sel=%b data=%h expected %h %b %b %h",
                             cyc, s_addr_o, s_we_o, s_sel_o, s_data_o,
                             t_addr[owner], t_we[owner], t_sel[owner], t_data[owner]);
                end
            end
            n_checks++;
            if (m0_ack_o !== (ack && owner == 0) || m1_ack_o !== (ack && owner == 1)) begin
                n_fails++;
                $display("FAIL rnd_ack@%0d: ack0=%b ack1=%b expected %b %b", cyc, m0_ack_o, m1_ack_o,
                         ack && owner == 0, ack && owner == 1);
            end
            n_checks++;
            if ({m0_err_o, m1_err_o, timeout_o} !== 3'b000 || m0_data_o !== s_data_i || m1_data_o !== s_data_i) begin
                n_fails++;
                $display("FAIL rnd_err_bcast@%0d: err0/err1/to=%b d0=%h d1=%h expected 000 %h %h",
                         cyc, {m0_err_o, m1_err_o, timeout_o}, m0_data_o, m1_data_o, s_data_i, s_data_i);
            end
            served = owner;
            if (ack && served >= 0 && !t_we[served]) begin
                n_checks++;
                if ((served == 0 && exp_q0.size() == 0) || (served == 1 && exp_q1.size() == 0)) begin
                    n_fails++; $display("FAIL rnd_rdata@%0d: read ack with empty expected queue", cyc);
                end else begin
                    exp_rd = (served == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    if (((served == 0) ? m0_data_o : m1_data_o) !== exp_rd) begin
                        n_fails++;
                        $display("FAIL rnd_rdata@%0d: m%0d data=%h expected %h", cyc, served,
                                 (served == 0) ? m0_data_o : m1_data_o, exp_rd);
                    end
                end
            end
            req0 = m0_cyc_i & m0_stb_i;
            req1 = m1_cyc_i & m1_stb_i;
            if (owner < 0) begin
                if (req0 && req1) owner = (last == 1) ? 0 : 1;
                else if (req0) owner = 0;
                else if (req1) owner = 1;
            end else if (ack) begin
                last = served;
                if ((served == 0) ? req1 : req0) owner = 1 - served;
                else if (!((served == 0) ? req0 : req1)) owner = -1;
                busy[served] = 1'b0;
            end else if (!((owner == 0) ? m0_stb_i : m1_stb_i)) begin
                owner = -1;
            end
            step();
        end
        n_checks++;
        if (busy[0] || busy[1] || exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_fails++;
            $display("FAIL rnd_drain: busy=%b%b pending reads=%0d/%0d expected all done",
                     busy[1], busy[0], exp_q1.size(), exp_q0.size());
        end
        drive_idle();
        step();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single_read();
        test_tie_first();
        test_back_to_back();
        test_timeout();
        test_ack_at_timeout();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
